// File: rtl/instruction_decode_stage_if.sv
// Handshake and decoded-payload bundle between fetch, the decode stage and the
// immediate extender / ALU side.
interface instruction_decode_stage_if #(
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 20
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_WIDTH-1:0]  pc_out;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [IMM_WIDTH-1:0] imm_raw;
    logic [1:0]           imm_ctrl;
    logic                 illegal;

    modport slave (
        input  in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
               funct3, funct7, imm_raw, imm_ctrl, illegal
    );

    modport master (
        output in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
               funct3, funct7, imm_raw, imm_ctrl, illegal
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: decodes fetched words and buffers the decoded bundle in a
// 2-entry skid buffer; every output is driven from the head entry registers.
module instruction_decode_stage #(
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    instruction_decode_stage_if.slave   bus
);
    typedef struct packed {
        logic [PC_WIDTH-1:0]  pc;
        logic [6:0]           opcode;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [IMM_WIDTH-1:0] imm_raw;
        logic [1:0]           imm_ctrl;
        logic                 illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d, tail_q, tail_d, dec;
    logic   in_ready_q;
    logic   push, pop;

    always_comb begin
        dec        = '0;
        dec.pc     = bus.pc_in;
        dec.opcode = bus.instr[6:0];
        dec.rd     = bus.instr[11:7];
        dec.funct3 = bus.instr[14:12];
        dec.rs1    = bus.instr[19:15];
        dec.rs2    = bus.instr[24:20];
        dec.funct7 = bus.instr[31:25];
        case (bus.instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                dec.imm_raw = IMM_WIDTH'(bus.instr[31:20]);
            7'b0100011:
                dec.imm_raw = IMM_WIDTH'({bus.instr[31:25], bus.instr[11:7]});
            7'b1100011: begin
                dec.imm_raw  = IMM_WIDTH'({bus.instr[31], bus.instr[7],
                                           bus.instr[30:25], bus.instr[11:8]});
                dec.imm_ctrl = 2'd1;
            end
            7'b0110111, 7'b0010111: begin
                dec.imm_raw  = IMM_WIDTH'(bus.instr[31:12]);
                dec.imm_ctrl = 2'd2;
            end
            7'b1101111: begin
                dec.imm_raw  = IMM_WIDTH'({bus.instr[31], bus.instr[19:12],
                                           bus.instr[20], bus.instr[30:21]});
                dec.imm_ctrl = 2'd3;
            end
            7'b0110011, 7'b1110011, 7'b0001111: ;
            default: dec.illegal = 1'b1;
        endcase
    end

    // flush wins over both handshakes; the in-flight word is simply dropped
    assign push = bus.in_valid && in_ready_q && !flush;
    assign pop  = (state_q != EMPTY) && bus.out_ready && !flush;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_d = ONE;
                    head_d  = dec;
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = dec;
                    end else if (push) begin
                        state_d = FULL;
                        tail_d  = dec;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.pc_out    = head_q.pc;
    assign bus.opcode    = head_q.opcode;
    assign bus.rd        = head_q.rd;
    assign bus.rs1       = head_q.rs1;
    assign bus.rs2       = head_q.rs2;
    assign bus.funct3    = head_q.funct3;
    assign bus.funct7    = head_q.funct7;
    assign bus.imm_raw   = head_q.imm_raw;
    assign bus.imm_ctrl  = head_q.imm_ctrl;
    assign bus.illegal   = head_q.illegal;
endmodule
